// File: rtl/pipe_skid_reg.sv
//------------------------------------------------------------------------------
// pipe_skid_reg : valid/ready pipeline stage with a 2-entry skid buffer,
//                 synchronous flush and a saturating stall counter.
// Revision      : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module pipe_skid_reg #(
   parameter int DATA_W = 32,
   parameter int CTRL_W = 8,
   parameter int CNT_W  = 16
) (
   input  logic              i_clk,
   input  logic              i_reset,
   input  logic              i_valid,
   output logic              o_ready,
   input  logic [DATA_W-1:0] i_data,
   input  logic [CTRL_W-1:0] i_ctrl,
   input  logic              i_flush,
   output logic              o_valid,
   input  logic              i_ready,
   output logic [DATA_W-1:0] o_data,
   output logic [CTRL_W-1:0] o_ctrl,
   output logic [1:0]        o_occupancy,
   output logic [CNT_W-1:0]  o_stall_cnt
);

   localparam logic [1:0] S_EMPTY = 2'd0;
   localparam logic [1:0] S_ONE   = 2'd1;
   localparam logic [1:0] S_FULL  = 2'd2;

   logic [1:0]        state_q,     state_d;
   logic [DATA_W-1:0] main_data_q, main_data_d;
   logic [CTRL_W-1:0] main_ctrl_q, main_ctrl_d;
   logic [DATA_W-1:0] skid_data_q, skid_data_d;
   logic [CTRL_W-1:0] skid_ctrl_q, skid_ctrl_d;
   logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;

   logic w_in_fire;
   logic w_out_fire;

   assign w_in_fire  = i_valid & o_ready;
   assign w_out_fire = o_valid & i_ready;

   always_ff @(posedge i_clk or negedge i_reset) begin
      if (!i_reset) begin
         state_q     <= S_EMPTY;
         main_data_q <= '0;
         main_ctrl_q <= '0;
         skid_data_q <= '0;
         skid_ctrl_q <= '0;
         stall_cnt_q <= '0;
      end else begin
         state_q     <= state_d;
         main_data_q <= main_data_d;
         main_ctrl_q <= main_ctrl_d;
         skid_data_q <= skid_data_d;
         skid_ctrl_q <= skid_ctrl_d;
         stall_cnt_q <= stall_cnt_d;
      end
   end

   always_comb begin
      state_d     = state_q;
      main_data_d = main_data_q;
      main_ctrl_d = main_ctrl_q;
      skid_data_d = skid_data_q;
      skid_ctrl_d = skid_ctrl_q;
      stall_cnt_d = stall_cnt_q;

      // Stall accounting ignores flush so a killed-while-stalled cycle still counts.
      if (o_valid && !i_ready && (stall_cnt_q != {CNT_W{1'b1}}))
         stall_cnt_d = stall_cnt_q + CNT_W'(1);

      if (i_flush) begin
         state_d     = S_EMPTY;
         main_ctrl_d = '0;
         skid_ctrl_d = '0;
      end else begin
         case (state_q)
            S_EMPTY: begin
               if (w_in_fire) begin
                  state_d     = S_ONE;
                  main_data_d = i_data;
                  main_ctrl_d = i_ctrl;
               end
            end
            S_ONE: begin
               if (w_in_fire && w_out_fire) begin
                  main_data_d = i_data;
                  main_ctrl_d = i_ctrl;
               end else if (w_in_fire) begin
                  state_d     = S_FULL;
                  skid_data_d = i_data;
                  skid_ctrl_d = i_ctrl;
               end else if (w_out_fire) begin
                  state_d     = S_EMPTY;
                  main_ctrl_d = '0;
               end
            end
            S_FULL: begin
               if (w_out_fire) begin
                  state_d     = S_ONE;
                  main_data_d = skid_data_q;
                  main_ctrl_d = skid_ctrl_q;
                  skid_ctrl_d = '0;
               end
            end
            default: begin
               state_d     = S_EMPTY;
               main_ctrl_d = '0;
               skid_ctrl_d = '0;
            end
         endcase
      end
   end

   always_comb begin
      o_valid     = (state_q != S_EMPTY);
      o_ready     = (state_q != S_FULL);
      o_occupancy = state_q;
      o_data      = main_data_q;
      o_ctrl      = o_valid ? main_ctrl_q : '0;
      o_stall_cnt = stall_cnt_q;
   end

endmodule

`default_nettype wire

// File: tb/tb_pipe_skid_reg.sv
//------------------------------------------------------------------------------
// tb_pipe_skid_reg : directed stimulus with a queue-based scoreboard for
//                    pipe_skid_reg (CNT_W=4 so saturation is reachable).
// Revision         : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_pipe_skid_reg;

   localparam int DATA_W = 32;
   localparam int CTRL_W = 8;
   localparam int CNT_W  = 4;

   logic              i_clk;
   logic              i_reset;
   logic              i_valid;
   logic              o_ready;
   logic [DATA_W-1:0] i_data;
   logic [CTRL_W-1:0] i_ctrl;
   logic              i_flush;
   logic              o_valid;
   logic              i_ready;
   logic [DATA_W-1:0] o_data;
   logic [CTRL_W-1:0] o_ctrl;
   logic [1:0]        o_occupancy;
   logic [CNT_W-1:0]  o_stall_cnt;

   int n_checks = 0;
   int n_pass   = 0;

   logic [DATA_W-1:0] exp_data[$];
   logic [CTRL_W-1:0] exp_ctrl[$];

   pipe_skid_reg #(
      .DATA_W (DATA_W),
      .CTRL_W (CTRL_W),
      .CNT_W  (CNT_W)
   ) dut (
      .i_clk       (i_clk),
      .i_reset     (i_reset),
      .i_valid     (i_valid),
      .o_ready     (o_ready),
      .i_data      (i_data),
      .i_ctrl      (i_ctrl),
      .i_flush     (i_flush),
      .o_valid     (o_valid),
      .i_ready     (i_ready),
      .o_data      (o_data),
      .o_ctrl      (o_ctrl),
      .o_occupancy (o_occupancy),
      .o_stall_cnt (o_stall_cnt)
   );

   initial i_clk = 1'b0;
   always #5 i_clk = ~i_clk;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
   endtask

   task automatic tick();
      @(posedge i_clk);
      #1;
   endtask

   task automatic push(input logic [DATA_W-1:0] d, input logic [CTRL_W-1:0] c);
      exp_data.push_back(d);
      exp_ctrl.push_back(c);
   endtask

   task automatic drive(input logic v, input logic [DATA_W-1:0] d, input logic [CTRL_W-1:0] c);
      i_valid = v;
      i_data  = d;
      i_ctrl  = c;
   endtask

   // Monitor: mid-cycle, a transfer is pending at the next edge when o_valid & i_ready.
   always @(negedge i_clk) begin
      if (i_reset) begin
         if (o_valid && i_ready) begin
            if (exp_data.size() == 0) begin
               check("unexpected_output", {32'd0, o_data}, 64'hDEAD_DEAD);
            end else begin
               check("out_data", {32'd0, o_data}, {32'd0, exp_data.pop_front()});
               check("out_ctrl", {56'd0, o_ctrl}, {56'd0, exp_ctrl.pop_front()});
            end
         end
         if (!o_valid) check("ctrl_zero_when_invalid", {56'd0, o_ctrl}, 64'd0);
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      i_reset = 1'b0;
      i_flush = 1'b0;
      i_ready = 1'b0;
      drive(1'b0, '0, '0);
      repeat (3) tick();
      i_reset = 1'b1;

      check("rst_occ",    {62'd0, o_occupancy}, 64'd0);
      check("rst_valid",  {63'd0, o_valid}, 64'd0);
      check("rst_ready",  {63'd0, o_ready}, 64'd1);
      check("rst_data",   {32'd0, o_data}, 64'd0);
      check("rst_ctrl",   {56'd0, o_ctrl}, 64'd0);
      check("rst_stall",  {60'd0, o_stall_cnt}, 64'd0);

      // 1: streaming
      i_ready = 1'b1;
      drive(1'b1, 32'h100, 8'h01); push(32'h100, 8'h01);
      tick();
      check("s1_valid", {63'd0, o_valid}, 64'd1);
      check("s1_data0", {32'd0, o_data}, 64'h100);
      drive(1'b1, 32'h104, 8'h02); push(32'h104, 8'h02);
      tick();
      check("s1_occ", {62'd0, o_occupancy}, 64'd1);
      drive(1'b1, 32'h108, 8'h03); push(32'h108, 8'h03);
      tick();
      check("s1_occ2", {62'd0, o_occupancy}, 64'd1);
      drive(1'b0, '0, '0);
      tick();
      check("s1_empty", {62'd0, o_occupancy}, 64'd0);
      check("s1_stall", {60'd0, o_stall_cnt}, 64'd0);

      // 2: backpressure, three stalled cycles
      i_ready = 1'b0;
      drive(1'b1, 32'hA, 8'h0A); push(32'hA, 8'h0A);
      tick();
      drive(1'b1, 32'hB, 8'h0B); push(32'hB, 8'h0B);
      tick();
      drive(1'b0, '0, '0);
      check("s2_occ_full", {62'd0, o_occupancy}, 64'd2);
      check("s2_ready",    {63'd0, o_ready}, 64'd0);
      check("s2_hold",     {32'd0, o_data}, 64'hA);
      tick();
      tick();
      check("s2_stall", {60'd0, o_stall_cnt}, 64'd3);
      i_ready = 1'b1;
      tick();
      check("s2_occ_one", {62'd0, o_occupancy}, 64'd1);
      tick();
      check("s2_drained", {62'd0, o_occupancy}, 64'd0);
      check("s2_stall_final", {60'd0, o_stall_cnt}, 64'd3);

      // 3: flush while FULL with a new input in the flush cycle
      i_ready = 1'b0;
      drive(1'b1, 32'h31, 8'hFF); push(32'h31, 8'hFF);
      tick();
      drive(1'b1, 32'h32, 8'hFF); push(32'h32, 8'hFF);
      tick();
      check("s3_full_ctrl", {56'd0, o_ctrl}, 64'hFF);
      drive(1'b1, 32'hC, 8'hFF);
      i_flush = 1'b1;
      tick();
      i_flush = 1'b0;
      drive(1'b0, '0, '0);
      exp_data.delete();
      exp_ctrl.delete();
      check("s3_valid", {63'd0, o_valid}, 64'd0);
      check("s3_ctrl",  {56'd0, o_ctrl}, 64'd0);
      check("s3_occ",   {62'd0, o_occupancy}, 64'd0);
      check("s3_ready", {63'd0, o_ready}, 64'd1);
      check("s3_stall", {60'd0, o_stall_cnt}, 64'd5);
      i_ready = 1'b1;
      repeat (2) tick();

      // 4: drain single entry to empty
      i_ready = 1'b0;
      drive(1'b1, 32'h44, 8'h05); push(32'h44, 8'h05);
      tick();
      drive(1'b0, '0, '0);
      check("s4_ctrl", {56'd0, o_ctrl}, 64'h05);
      i_ready = 1'b1;
      tick();
      check("s4_valid", {63'd0, o_valid}, 64'd0);
      check("s4_ctrl0", {56'd0, o_ctrl}, 64'd0);
      check("s4_stall", {60'd0, o_stall_cnt}, 64'd5);

      // 5: saturation of the 4-bit counter
      i_ready = 1'b0;
      drive(1'b1, 32'h50, 8'h11); push(32'h50, 8'h11);
      tick();
      drive(1'b0, '0, '0);
      repeat (20) tick();
      check("s5_sat", {60'd0, o_stall_cnt}, 64'd15);
      repeat (2) tick();
      check("s5_sat_hold", {60'd0, o_stall_cnt}, 64'd15);
      i_flush = 1'b1;
      tick();
      i_flush = 1'b0;
      exp_data.delete();
      exp_ctrl.delete();
      check("s5_flush_keep", {60'd0, o_stall_cnt}, 64'd15);
      check("s5_occ", {62'd0, o_occupancy}, 64'd0);

      // 6: asynchronous reset while FULL, asserted between edges
      drive(1'b1, 32'h61, 8'h21); push(32'h61, 8'h21);
      tick();
      drive(1'b1, 32'h62, 8'h22); push(32'h62, 8'h22);
      tick();
      drive(1'b0, '0, '0);
      check("s6_full", {62'd0, o_occupancy}, 64'd2);
      #2;
      i_reset = 1'b0;
      #1;
      exp_data.delete();
      exp_ctrl.delete();
      check("s6_rst_occ",   {62'd0, o_occupancy}, 64'd0);
      check("s6_rst_valid", {63'd0, o_valid}, 64'd0);
      check("s6_rst_ready", {63'd0, o_ready}, 64'd1);
      check("s6_rst_data",  {32'd0, o_data}, 64'd0);
      check("s6_rst_ctrl",  {56'd0, o_ctrl}, 64'd0);
      check("s6_rst_stall", {60'd0, o_stall_cnt}, 64'd0);
      tick();
      i_reset = 1'b1;
      i_ready = 1'b1;
      drive(1'b1, 32'h55, 8'h00); push(32'h55, 8'h00);
      tick();
      drive(1'b0, '0, '0);
      check("s6_lat_valid", {63'd0, o_valid}, 64'd1);
      check("s6_lat_data",  {32'd0, o_data}, 64'h55);
      tick();
      check("s6_empty", {62'd0, o_occupancy}, 64'd0);
      repeat (2) tick();
      check("sb_empty", 64'(exp_data.size()), 64'd0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/pipe_skid_reg.md
Name: pipe_skid_reg

Overview:
Parametrised pipeline-stage register with a valid/ready handshake, a 2-entry skid buffer, synchronous flush and a stall counter. It generalises the fixed-field stage registers (IF/ID … MEM/WB) into one reusable block.
- Payload width is configurable.
- Control bits (write-enables, valid-insn, ctrl-transfer) are separated from data so a flush or bubble never leaves a write-enable asserted.
- It sits between any two pipeline stages or between the core and the IO output registers.

Parameters:
DATA_W, 32, width of the data payload (PC, ALU/WB data, rd address, IO images packed by the instantiator)
CTRL_W, 8, width of the control payload; forced to 0 whenever the stage holds no valid entry
CNT_W, 16, width of the saturating stall counter

Ports:
i_clk  input  1  clock, rising edge
i_reset  input  1  asynchronous, active-low reset
i_valid  input  1  upstream entry valid
o_ready  output  1  stage can accept an entry this cycle
i_data  input  DATA_W  upstream data payload
i_ctrl  input  CTRL_W  upstream control payload
i_flush  input  1  synchronous kill of all held entries (e.g. mispredict)
o_valid  output  1  output entry valid
i_ready  input  1  downstream accepts the output entry
o_data  output  DATA_W  output data payload
o_ctrl  output  CTRL_W  output control payload; 0 when o_valid=0
o_occupancy  output  2  entries held (0, 1 or 2)
o_stall_cnt  output  CNT_W  cycles with o_valid=1 and i_ready=0, saturating

Behaviour:
- Handshake definitions:
  - in_fire = i_valid & o_ready
  - out_fire = o_valid & i_ready
- Storage:
  - main register drives o_data/o_ctrl.
  - skid register is filled only when main is valid and not draining.
- State = occupancy: EMPTY(0), ONE(1), FULL(2).
  - o_valid = (state != EMPTY).
  - o_ready = (state != FULL). Both are decoded from registered state only, with no combinational path from i_ready or i_valid.
- Transitions (evaluated only when i_flush=0):
  - EMPTY: in_fire -> ONE, main<=in.
  - ONE: in_fire & out_fire -> ONE, main<=in. in_fire & !out_fire -> FULL, skid<=in. !in_fire & out_fire -> EMPTY. Neither -> hold.
  - FULL: out_fire -> ONE, main<=skid. Otherwise hold. No input is accepted in FULL because o_ready=0.
- Latency and ordering:
  - Latency is 1 cycle from in_fire to o_valid when empty.
  - Order is strictly FIFO.
  - Throughput is 1 entry/cycle in steady state.
- Flush:
  - i_flush=1 has highest priority. The next state is EMPTY, o_valid=0 and o_ctrl=0.
  - The skid entry is discarded.
  - Any i_valid in the same cycle is dropped.
  - out_fire in the flush cycle still counts as a transfer for the downstream stage; the upstream stage must not count a dropped in_fire.
- Control and data on invalid entries:
  - The ctrl field of any register is cleared to 0 whenever that entry becomes invalid (drain or flush).
  - o_data keeps its last value when invalid and must not be relied on.
- Stall counter:
  - Increments each cycle with o_valid & !i_ready, including the cycle in which i_flush is asserted.
  - Saturates at 2^CNT_W-1 and never wraps.
  - Cleared only by reset; flush does not clear it.
- Reset (async, active-low, any time including mid-transfer):
  - state=EMPTY, o_valid=0, o_ready=1 after release.
  - o_data=0, o_ctrl=0, skid=0, o_occupancy=0, o_stall_cnt=0.
  - Entries held at reset are lost.
- Widths: o_occupancy = state encoding. No arithmetic beyond the counter increment.

Test Plan:
1. Reset then stream: i_valid=1, i_ready=1, data 0x100,0x104,0x108 -> o_valid rises 1 cycle later, o_data 0x100,0x104,0x108 on consecutive cycles, occupancy stays 1, stall_cnt=0.
2. Backpressure: send 0xA, 0xB with i_ready=0 -> occupancy 2, o_ready=0, o_data=0xA held. Raise i_ready -> outputs 0xA then 0xB, no loss or duplication. stall_cnt equals the number of low-ready cycles with o_valid=1.
3. Flush while FULL with i_ctrl=8'hFF on both entries and i_valid=1 with 0xC in the flush cycle -> next cycle o_valid=0, o_ctrl=0, occupancy 0, o_ready=1. 0xC is never emitted.
4. Drain to empty: a single entry with ctrl 8'h05 then i_ready=1 and no input -> o_valid=0 and o_ctrl=0 the cycle after transfer.
5. Saturation with CNT_W=4: hold o_valid=1, i_ready=0 for 20 cycles -> o_stall_cnt=15 and stays 15. Subsequent flush leaves it at 15.
6. Async reset mid-FULL, asserted off-edge -> outputs go to 0/EMPTY immediately, without waiting for a clock edge. After release, first accepted entry 0x55 appears 1 cycle later.
